kinase_valve_sequencer: RTL and testbench

//  Off-chip pneumatic driver for the kinase_activity_2 chip control pads.

---
 rtl/kinase_valve_sequencer_if.sv | 11 +
 rtl/kinase_valve_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_kinase_valve_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kinase_valve_sequencer_if.sv
// Command port of the kinase valve sequencer: valid/ready handshake with
// a 2-bit opcode and a 17-bit argument.
interface kinase_valve_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [16:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: drives the kinase_activity_2 pneumatic control
// pads. Commands (SET_VALVES, PUMP_A, PUMP_B, WAIT) arrive on a valid/ready
// port. Each command is then played out as a timed valve pattern or as a
// series of peristaltic phase steps. An output bit of 1 means the line is
// pressurised, so the valve is closed.
// Optional feature: define KINASE_PUMP_REVERSE_EN to let cmd_arg[16] reverse
// the pump phase order. When it is undefined, pumps always run forward.
module kinase_valve_sequencer #(
  parameter int PHASE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  kinase_valve_sequencer_if.slave  cmd,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [12:0]              ctrl_a,
  output logic [3:0]               ctrl_s,
  output logic [2:0]               pump_a,
  output logic [1:0]               pump_b
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = (CNT_W > SW) ? CNT_W : SW;
  localparam int PW = $clog2(PHASE_CYCLES + 1);

  localparam logic [1:0] OP_SET    = 2'd0;
  localparam logic [1:0] OP_PUMP_A = 2'd1;
  localparam logic [1:0] OP_PUMP_B = 2'd2;

  typedef enum logic [2:0] {IDLE, SETTLE, PUMP_A, PUMP_B, WAIT} state_t;

  state_t           state;
  logic [RW-1:0]    rem;        // cycles left in SETTLE/WAIT, minus one
  logic [PW-1:0]    phase_cnt;  // cycles left in the current phase, minus one
  logic [1:0]       phase;      // phase index within the current stroke
  logic [CNT_W-1:0] strokes;    // strokes remaining after the current one
  logic             rev;        // reversed phase order for this command
  logic             arg_rev;
  logic [CNT_W-1:0] cmd_count;
  logic             accept;

`ifdef KINASE_PUMP_REVERSE_EN
  assign arg_rev = cmd.cmd_arg[16];
`else
  assign arg_rev = 1'b0;
`endif

  assign cmd_count = cmd.cmd_arg[CNT_W-1:0];
  // Abort takes priority, so a command offered in the same cycle is dropped.
  assign accept    = cmd.cmd_valid && cmd.cmd_ready && !abort;

  function automatic logic [2:0] pat_a(input logic [1:0] ph, input logic r);
    logic [1:0] idx;
    idx = r ? (2'd2 - ph) : ph;
    case (idx)
      2'd0:    pat_a = 3'b110;
      2'd1:    pat_a = 3'b101;
      default: pat_a = 3'b011;
    endcase
  endfunction

  function automatic logic [1:0] pat_b(input logic ph, input logic r);
    pat_b = (ph ^ r) ? 2'b01 : 2'b10;
  endfunction

  // Command FSM. All outputs are registered and move together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd.cmd_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      ctrl_a        <= '0;
      ctrl_s        <= '0;
      pump_a        <= 3'b111;
      pump_b        <= 2'b11;
      rem           <= '0;
      phase_cnt     <= '0;
      phase         <= '0;
      strokes       <= '0;
      rev           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          cmd.cmd_ready <= 1'b0;
          busy          <= 1'b1;
          rev           <= arg_rev;
          phase         <= 2'd0;
          phase_cnt     <= PW'(PHASE_CYCLES - 1);
          strokes       <= cmd_count - CNT_W'(1);
          rem           <= '0;
          case (cmd.cmd_op)
            OP_SET: begin
              ctrl_a <= cmd.cmd_arg[12:0];
              ctrl_s <= cmd.cmd_arg[16:13];
              rem    <= RW'(SETTLE_CYCLES - 1);
              state  <= SETTLE;
            end
            OP_PUMP_A: begin
              // A zero-stroke pump behaves as a one-cycle wait.
              if (cmd_count == '0) state <= WAIT;
              else begin
                state  <= PUMP_A;
                pump_a <= pat_a(2'd0, arg_rev);
              end
            end
            OP_PUMP_B: begin
              if (cmd_count == '0) state <= WAIT;
              else begin
                state  <= PUMP_B;
                pump_b <= pat_b(1'b0, arg_rev);
              end
            end
            default: begin
              state <= WAIT;
              if (cmd_count != '0) rem <= RW'(cmd_count) - RW'(1);
            end
          endcase
        end
      end else if (abort) begin
        state         <= IDLE;
        cmd.cmd_ready <= 1'b1;
        busy          <= 1'b0;
        pump_a        <= 3'b111;
        pump_b        <= 2'b11;
      end else begin
        case (state)
          SETTLE, WAIT: begin
            if (rem == '0) begin
              state         <= IDLE;
              cmd.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              rem <= rem - RW'(1);
            end
          end
          PUMP_A: begin
            if (phase_cnt != '0) phase_cnt <= phase_cnt - PW'(1);
            else if (phase != 2'd2) begin
              phase     <= phase + 2'd1;
              phase_cnt <= PW'(PHASE_CYCLES - 1);
              pump_a    <= pat_a(phase + 2'd1, rev);
            end else if (strokes != '0) begin
              strokes   <= strokes - CNT_W'(1);
              phase     <= 2'd0;
              phase_cnt <= PW'(PHASE_CYCLES - 1);
              pump_a    <= pat_a(2'd0, rev);
            end else begin
              state         <= IDLE;
              cmd.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
              pump_a        <= 3'b111;
            end
          end
          PUMP_B: begin
            if (phase_cnt != '0) phase_cnt <= phase_cnt - PW'(1);
            else if (phase == 2'd0) begin
              phase     <= 2'd1;
              phase_cnt <= PW'(PHASE_CYCLES - 1);
              pump_b    <= pat_b(1'b1, rev);
            end else if (strokes != '0) begin
              strokes   <= strokes - CNT_W'(1);
              phase     <= 2'd0;
              phase_cnt <= PW'(PHASE_CYCLES - 1);
              pump_b    <= pat_b(1'b0, rev);
            end else begin
              state         <= IDLE;
              cmd.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
              pump_b        <= 2'b11;
            end
          end
          default: begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Self-checking bench for kinase_valve_sequencer (PHASE_CYCLES=4, SETTLE_CYCLES=8).
// A timeline model derives every output from the time elapsed since a command
// was accepted, and that model is compared against the DUT on every cycle.
// Directed steps add literal latency and value checks that pin the model.
module tb_kinase_valve_sequencer;
  localparam int P = 4;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [12:0] ctrl_a;
  logic [3:0]  ctrl_s;
  logic [2:0]  pump_a;
  logic [1:0]  pump_b;

  kinase_valve_sequencer_if bus();

  kinase_valve_sequencer #(.PHASE_CYCLES(P), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .abort(abort), .busy(busy), .done(done),
    .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_rev    = 0;
  int          m_k = 0, m_len = 0, m_n = 0;
  logic [1:0]  m_op = 2'd0;
  logic [12:0] m_ca = '0;
  logic [3:0]  m_cs = '0;

  // Track the active command and the time elapsed since it was accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_ca = '0; m_cs = '0; m_k = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (abort) m_active = 0;
        else begin
          m_k++;
          if (m_k == m_len) begin m_active = 0; m_done = 1; end
        end
      end else if (bus.cmd_valid && !abort) begin
        m_active = 1;
        m_k  = 0;
        m_op = bus.cmd_op;
        m_n  = int'(bus.cmd_arg[15:0]);
`ifdef KINASE_PUMP_REVERSE_EN
        m_rev = bus.cmd_arg[16];
`else
        m_rev = 0;
`endif
        case (bus.cmd_op)
          2'd0: begin m_len = S; m_ca = bus.cmd_arg[12:0]; m_cs = bus.cmd_arg[16:13]; end
          2'd1: m_len = (m_n == 0) ? 1 : 3 * m_n * P;
          2'd2: m_len = (m_n == 0) ? 1 : 2 * m_n * P;
          default: m_len = (m_n == 0) ? 1 : m_n;
        endcase
      end
    end
  end

  function automatic logic [2:0] exp_pa();
    int ph;
    if (!(m_active && m_op == 2'd1 && m_n != 0)) return 3'b111;
    ph = (m_k / P) % 3;
    if (m_rev) ph = 2 - ph;
    return (ph == 0) ? 3'b110 : (ph == 1) ? 3'b101 : 3'b011;
  endfunction

  function automatic logic [1:0] exp_pb();
    int ph;
    if (!(m_active && m_op == 2'd2 && m_n != 0)) return 2'b11;
    ph = (m_k / P) % 2;
    if (m_rev) ph = 1 - ph;
    return (ph == 0) ? 2'b10 : 2'b01;
  endfunction

  // Compare every DUT output against the model once per cycle, on the falling edge.
  always @(negedge clk) begin
    chk("outputs{ready,busy,done,ctrl_a,ctrl_s,pump_a,pump_b}",
        64'({bus.cmd_ready, busy, done, ctrl_a, ctrl_s, pump_a, pump_b}),
        64'({!m_active, m_active, m_done, m_ca, m_cs, exp_pa(), exp_pb()}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [16:0] arg);
    bit ok = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_arg = arg;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready && !abort) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    t_acc = cyc;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
  endtask

  task automatic wait_done(input string nm, input int exp_len);
    bit seen = 0;
    for (int i = 0; i < exp_len + 50; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no done expected done after %0d cycles", nm, exp_len);
    end else chk(nm, 64'(cyc - t_acc), 64'(exp_len));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_arg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pump_a", 64'(pump_a), 64'h7);
    chk("reset_pump_b", 64'(pump_b), 64'h3);
    chk("reset_ctrl_a", 64'(ctrl_a), 64'h0);
    chk("reset_ready",  64'(bus.cmd_ready), 64'h1);
    chk("reset_done",   64'(done), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // abort while idle has no effect
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    chk("idle_abort_ready", 64'(bus.cmd_ready), 64'h1);

    // SET_VALVES
    send(2'd0, 17'h1_2345);
    chk("set_ctrl_a", 64'(ctrl_a), 64'h0345);
    chk("set_ctrl_s", 64'(ctrl_s), 64'h9);
    chk("set_ready_low", 64'(bus.cmd_ready), 64'h0);
    // offer a command while busy, then withdraw it; it must be ignored
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_arg = 17'd5;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    wait_done("set_latency", 8);

    // PUMP_A 2 strokes
    send(2'd1, 17'd2);
    chk("pa_first_phase", 64'(pump_a), 64'h6);
    wait_done("pump_a2_latency", 24);
    chk("pa_idle_after", 64'(pump_a), 64'h7);
    chk("pa_ctrl_a_kept", 64'(ctrl_a), 64'h0345);

    // zero-count commands and WAIT
    send(2'd2, 17'd0);
    chk("pb0_pattern", 64'(pump_b), 64'h3);
    wait_done("pump_b0_latency", 1);
    send(2'd3, 17'd0);
    wait_done("wait0_latency", 1);
    send(2'd3, 17'd5);
    wait_done("wait5_latency", 5);

    // PUMP_A 3 strokes aborted at cycle 6, next command held valid meanwhile
    send(2'd1, 17'd3);
    repeat (5) @(posedge clk);
    #1;
    abort = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_arg = 17'd2;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_pump_a_idle", 64'(pump_a), 64'h7);
    chk("abort_ready", 64'(bus.cmd_ready), 64'h1);
    chk("abort_no_done", 64'(done), 64'h0);
    @(posedge clk); #1;
    t_acc = cyc;
    bus.cmd_valid = 1'b0;
    chk("b2b_accepted", 64'(bus.cmd_ready), 64'h0);
    wait_done("b2b_wait_latency", 2);

    // PUMP_B 1 stroke with arg[16] set
    send(2'd2, 17'h1_0001);
`ifdef KINASE_PUMP_REVERSE_EN
    chk("pb_rev_first_phase", 64'(pump_b), 64'h1);
`else
    chk("pb_fwd_first_phase", 64'(pump_b), 64'h2);
`endif
    wait_done("pump_b1_latency", 8);
    chk("pb_idle_after", 64'(pump_b), 64'h3);

    // PUMP_A 1 stroke with arg[16] set
    send(2'd1, 17'h1_0001);
`ifdef KINASE_PUMP_REVERSE_EN
    chk("pa_rev_first_phase", 64'(pump_a), 64'h3);
`else
    chk("pa_fwd_first_phase", 64'(pump_a), 64'h6);
`endif
    wait_done("pump_a1_latency", 12);

    // reset in the middle of a command
    send(2'd2, 17'd2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_pump_b", 64'(pump_b), 64'h3);
    chk("midreset_ready", 64'(bus.cmd_ready), 64'h1);
    chk("midreset_ctrl_a", 64'(ctrl_a), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SET after reset
    send(2'd0, 17'h0_1FFF);
    chk("set2_ctrl_a", 64'(ctrl_a), 64'h1FFF);
    chk("set2_ctrl_s", 64'(ctrl_s), 64'h0);
    wait_done("set2_latency", 8);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
